// File: rtl/uart_block_receiver_pkg.sv
// Shared definitions for the UART block receiver: receive FSM states,
// default line timing, and the block width the AES core consumes.
package uart_block_receiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;

   localparam int DEFAULT_CLK_FREQ = 50_000_000;
   localparam int DEFAULT_BAUDRATE = 115_200;
   localparam int BLOCK_WIDTH      = 128;
   localparam int BLOCK_BYTES      = BLOCK_WIDTH / 8;

   function automatic int clks_per_bit(input int clk_freq, input int baudrate);
      return clk_freq / baudrate;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer feeding a start/data/stop FSM.
// Emits one-cycle byte_valid or frame_err pulses and a start_det pulse.
module uart_rx_byte
   import uart_block_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       start_det,
   output logic       idle
);

   localparam int          HALF_BIT  = CLKS_PER_BIT / 2;
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

   rx_state_t   state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        byte_valid_q, byte_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        start_det_q, start_det_d;

   always_comb begin
      sync1_d      = rx;
      sync2_d      = sync1_q;
      state_d      = state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      start_det_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!sync2_q) begin
               state_d     = ST_START;
               clk_cnt_d   = '0;
               bit_cnt_d   = '0;
               start_det_d = 1'b1;
            end
         end
         // Re-check the line mid start bit so short glitches fall back to idle.
         ST_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               state_d   = sync2_q ? ST_IDLE : ST_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {sync2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               state_d   = ST_IDLE;
               if (sync2_q) begin
                  byte_d       = shift_q;
                  byte_valid_d = 1'b1;
               end else begin
                  frame_err_d  = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         start_det_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         start_det_q  <= start_det_d;
      end
   end

   assign byte_data  = byte_q;
   assign byte_valid = byte_valid_q;
   assign frame_err  = frame_err_q;
   assign start_det  = start_det_q;
   assign idle       = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_block_receiver.sv
// Collects 16 UART bytes into a 128-bit block for the AES core, with a
// valid/ready handshake, sticky overrun and an idle timeout for partial blocks.
module uart_block_receiver
   import uart_block_receiver_pkg::*;
#(
   parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
   parameter int BAUDRATE     = DEFAULT_BAUDRATE,
   parameter int TIMEOUT_BITS = 20
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx,
   output logic [BLOCK_WIDTH-1:0] block_data,
   output logic                   block_valid,
   input  logic                   block_ready,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy
);

   localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

   logic [7:0]             rx_byte;
   logic                   rx_byte_valid;
   logic                   rx_start_det;
   logic                   rx_idle;
   logic                   transfer;

   logic [BLOCK_WIDTH-1:0] block_q, block_d;
   logic [3:0]             byte_cnt_q, byte_cnt_d;
   logic                   block_valid_q, block_valid_d;
   logic                   overrun_q, overrun_d;
   logic [31:0]            idle_cnt_q, idle_cnt_d;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_byte (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_data  (rx_byte),
      .byte_valid (rx_byte_valid),
      .frame_err  (frame_err),
      .start_det  (rx_start_det),
      .idle       (rx_idle)
   );

   assign transfer = block_valid_q && block_ready;

   always_comb begin
      block_d       = block_q;
      byte_cnt_d    = byte_cnt_q;
      block_valid_d = block_valid_q;
      overrun_d     = overrun_q;
      idle_cnt_d    = idle_cnt_q;

      if (transfer) begin
         block_valid_d = 1'b0;
      end

      // A byte landing on the transfer cycle already belongs to the next block.
      if (rx_byte_valid) begin
         if (block_valid_q && !transfer) begin
            overrun_d = 1'b1;
         end else begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
               if (byte_cnt_q == 4'(i)) begin
                  block_d[BLOCK_WIDTH-1-8*i -: 8] = rx_byte;
               end
            end
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
               block_valid_d = 1'b1;
            end
         end
      end

      if (rx_start_det || byte_cnt_q == 4'd0) begin
         idle_cnt_d = '0;
      end else if (rx_idle) begin
         if (idle_cnt_q == TIMEOUT_LAST) begin
            idle_cnt_d = '0;
            if (!rx_byte_valid) begin
               byte_cnt_d = '0;
            end
         end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         block_q       <= '0;
         byte_cnt_q    <= '0;
         block_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         idle_cnt_q    <= '0;
      end else begin
         block_q       <= block_d;
         byte_cnt_q    <= byte_cnt_d;
         block_valid_q <= block_valid_d;
         overrun_q     <= overrun_d;
         idle_cnt_q    <= idle_cnt_d;
      end
   end

   assign block_data  = block_q;
   assign block_valid = block_valid_q;
   assign overrun     = overrun_q;
   assign busy        = !rx_idle || (byte_cnt_q != 4'd0);

endmodule

// File: tb/tb_uart_block_receiver.sv
// Scoreboard bench for uart_block_receiver: expected blocks are queued as
// bytes are sent and compared whenever a block is handed over.
module tb_uart_block_receiver;

   localparam int CLK_FREQ     = 50_000_000;
   localparam int BAUDRATE     = 781_250;
   localparam int TIMEOUT_BITS = 20;
   localparam int CLK_PERIOD   = 20;
   localparam int BIT_TIME     = (CLK_FREQ / BAUDRATE) * CLK_PERIOD;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rx = 1'b1;
   logic         block_ready = 1'b0;
   logic [127:0] block_data;
   logic         block_valid;
   logic         frame_err;
   logic         overrun;
   logic         busy;

   int           tests_run = 0;
   int           tests_failed = 0;
   int           block_count = 0;
   int           frame_err_count = 0;
   logic [127:0] expected_q[$];

   uart_block_receiver #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUDRATE     (BAUDRATE),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .block_data  (block_data),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #(CLK_PERIOD / 2) clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Handshakes pop the scoreboard; frame errors are tallied per cycle seen.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err) frame_err_count++;
         if (block_valid && block_ready) begin
            block_count++;
            if (expected_q.size() == 0) begin
               checkOutput("unexpectedBlock", block_data, 128'h0);
            end else begin
               checkOutput("blockData", block_data, expected_q.pop_front());
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
      rx = 1'b0;
      #(BIT_TIME);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         #(BIT_TIME);
      end
      rx = stop_bit;
      #(BIT_TIME);
      rx = 1'b1;
      if (!stop_bit) #(BIT_TIME);
   endtask

   task automatic sendBlock(input logic [127:0] blk);
      expected_q.push_back(blk);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(blk[127-8*i -: 8], 1'b1);
      end
   endtask

   task automatic waitBlocks(input int target);
      int n = 0;
      while (block_count < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("blockCount", 128'(block_count), 128'(target));
   endtask

   task automatic setReady(input logic value);
      @(posedge clk);
      #1 block_ready = value;
   endtask

   initial begin
      logic [127:0] blk;
      int           fe_before;

      // Reset state
      repeat (5) @(negedge clk);
      checkOutput("rstValid", 128'(block_valid), 128'h0);
      checkOutput("rstData", block_data, 128'h0);
      checkOutput("rstFrameErr", 128'(frame_err), 128'h0);
      checkOutput("rstOverrun", 128'(overrun), 128'h0);
      checkOutput("rstBusy", 128'(busy), 128'h0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Basic block with ready held high
      setReady(1'b1);
      sendBlock(128'h00FF00007A9B9B9B86D2D27A7A7B7A86);
      waitBlocks(1);

      // Short low glitch while idle
      fe_before = frame_err_count;
      rx = 1'b0;
      #500;
      rx = 1'b1;
      #(2 * BIT_TIME);
      @(negedge clk);
      checkOutput("glitchBusy", 128'(busy), 128'h0);
      checkOutput("glitchFrameErr", 128'(frame_err_count), 128'(fe_before));
      checkOutput("glitchBlocks", 128'(block_count), 128'd1);

      // Bad stop bit, then a clean block must not be shifted
      fe_before = frame_err_count;
      applyStimulus(8'h55, 1'b0);
      checkOutput("frameErrPulse", 128'(frame_err_count), 128'(fe_before + 1));
      checkOutput("frameErrBusy", 128'(busy), 128'h0);
      blk = '0;
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(i * 17 + 3);
      sendBlock(blk);
      waitBlocks(2);

      // Overrun while the block is held
      setReady(1'b0);
      blk = 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE;
      sendBlock(blk);
      @(negedge clk);
      checkOutput("heldValid", 128'(block_valid), 128'h1);
      checkOutput("noOverrunYet", 128'(overrun), 128'h0);
      applyStimulus(8'h11, 1'b1);
      @(negedge clk);
      checkOutput("overrunSet", 128'(overrun), 128'h1);
      checkOutput("heldData", block_data, blk);
      checkOutput("heldBlocks", 128'(block_count), 128'd2);
      setReady(1'b1);
      waitBlocks(3);
      @(negedge clk);
      @(negedge clk);
      checkOutput("validCleared", 128'(block_valid), 128'h0);
      checkOutput("overrunSticky", 128'(overrun), 128'h1);
      checkOutput("busyAfterDrop", 128'(busy), 128'h0);

      // Partial block discarded after idle timeout
      for (int i = 0; i < 5; i++) applyStimulus(8'hA0 + 8'(i), 1'b1);
      @(negedge clk);
      checkOutput("partialBusy", 128'(busy), 128'h1);
      #(25 * BIT_TIME);
      @(negedge clk);
      checkOutput("timeoutBusy", 128'(busy), 128'h0);
      sendBlock(128'h0102030405060708090A0B0C0D0E0F10);
      waitBlocks(4);

      // Reset during bit 4 of byte 7
      for (int i = 0; i < 6; i++) applyStimulus(8'h30 + 8'(i), 1'b1);
      rx = 1'b0;
      #(BIT_TIME);
      for (int i = 0; i < 4; i++) begin
         rx = 1'(8'h5C >> i);
         #(BIT_TIME);
      end
      rx = 1'b1;
      #(BIT_TIME / 2);
      @(negedge clk);
      reset = 1'b1;
      #2;
      checkOutput("midRstValid", 128'(block_valid), 128'h0);
      checkOutput("midRstData", block_data, 128'h0);
      checkOutput("midRstFrameErr", 128'(frame_err), 128'h0);
      checkOutput("midRstOverrun", 128'(overrun), 128'h0);
      checkOutput("midRstBusy", 128'(busy), 128'h0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      sendBlock(128'hFEDCBA98765432100011223344556677);
      waitBlocks(5);
      @(negedge clk);
      checkOutput("finalOverrun", 128'(overrun), 128'h0);
      checkOutput("queueEmpty", 128'(expected_q.size()), 128'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_block_receiver.md
UART_BLOCK_RECEIVER -- requirements
Module: uart_block_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115_200, serial bit rate.
REQ-003 Parameter TIMEOUT_BITS, default 20, idle bit-times after which a partial block is discarded.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous UART line: 8N1, LSB first, idle high.
REQ-007 block_data  output  128  assembled 16-byte block; first received byte in [127:120], last in [7:0].
REQ-008 block_valid  output  1  block_data holds a complete block.
REQ-009 block_ready  input  1  downstream (AES core) accepts the block.
REQ-010 frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-011 overrun  output  1  sticky flag: a byte arrived while block_valid was high and not accepted.
REQ-012 busy  output  1  high whenever the receive FSM is not in IDLE or byte count is nonzero.

Function
REQ-013 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUDRATE, integer-truncated (434 at defaults); half-bit = CLKS_PER_BIT/2.
REQ-014 rx SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on synchronized rx low; bit counter cleared.
REQ-017 START: at half-bit, rx low -> DATA with counter cleared; rx high -> IDLE (glitch rejected, no error).
REQ-018 DATA: sample rx every CLKS_PER_BIT cycles, shift in LSB first; after 8th sample -> STOP.
REQ-019 STOP: sample at CLKS_PER_BIT; high -> byte accepted, low -> frame_err pulse, byte discarded, byte count unchanged; both -> IDLE.
REQ-020 Accepted byte SHALL be written into byte slot byte_cnt (slot 0 = [127:120]); byte_cnt 4-bit, increments and wraps 15 -> 0.
REQ-021 On acceptance of slot 15, block_valid SHALL rise the next cycle, with block_data stable while block_valid is high.
REQ-022 Handshake: transfer occurs on a cycle with block_valid and block_ready both high; block_valid clears the following cycle.
REQ-023 Byte accepted while block_valid high and no transfer that cycle: byte dropped, overrun set; holding block unchanged.
REQ-024 Byte acceptance coinciding with a transfer cycle: byte SHALL be stored into slot 0 of the new block, no overrun.
REQ-025 overrun clears only on reset.
REQ-026 Idle timer counts cycles in IDLE with byte_cnt nonzero; at TIMEOUT_BITS*CLKS_PER_BIT cycles byte_cnt resets to 0 (partial block discarded), no flag.
REQ-027 Idle timer SHALL clear on every start-bit detection.
REQ-028 block_ready while block_valid low SHALL have no effect.

Reset
REQ-029 On reset assertion, immediately: FSM IDLE, byte_cnt 0, block_data 0, block_valid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1, all counters 0.
REQ-030 Reset mid-byte or mid-block SHALL discard all partial data; first falling edge after release starts a fresh byte in slot 0.

Structure
REQ-031 Shared package holds the FSM state enum, default CLK_FREQ/BAUDRATE values, and the 128-bit block width constant used by the AES core.
REQ-032 One sub-module, uart_rx_byte (synchronizer + FSM, outputs byte + byte_valid + frame_err), instantiated once; block assembly, handshake and timeout live in the top.

Verification
REQ-033 Send bytes 00 FF 00 00 7A 9B 9B 9B 86 D2 D2 7A 7A 7B 7A 86, block_ready high -> one block_valid pulse, block_data = 00FF00007A9B9B9B86D2D27A7A7B7A86.
REQ-034 0.5 us low glitch on rx in IDLE -> no byte, no frame_err, byte_cnt stays 0.
REQ-035 Byte 0x55 with stop bit driven low -> single frame_err pulse; following 16 good bytes form the block without shift.
REQ-036 block_ready low, 16 bytes then byte 0x11 -> overrun 1, block_data unchanged; raise block_ready -> transfer, overrun stays 1.
REQ-037 Send 5 bytes, hold rx high 25 bit-times, send 16 bytes 0x01..0x10 -> block_data = 0102...0F10.
REQ-038 Assert reset during bit 4 of byte 7 -> all outputs 0 immediately; next 16 bytes form a complete correct block.
